// File: rtl/priority_decoder_3to8.sv
// Registered 3-to-8 one-hot decoder that holds each accepted code for HOLD_CYCLES cycles.
// Optional acceptance counter (dec_count) is compiled in when DEC_COUNT_EN is defined.
module priority_decoder_3to8 #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] input_data,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       out_valid
`ifdef DEC_COUNT_EN
    ,
    output logic [7:0] dec_count
`endif
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    localparam logic [3:0] CntLoad = 4'(HOLD_CYCLES - 1);

    state_e     r_state;
    state_e     w_state_d;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_d;
    logic [7:0] r_out;
    logic [7:0] w_out_d;
    logic       w_accept;

    generate
        if (HOLD_CYCLES == 0 || HOLD_CYCLES > 15) begin : g_bad_hold_cycles
            $error("HOLD_CYCLES must be in 1..15");
        end
    endgenerate

    // Ready is gated by reset so nothing is accepted on a reset edge.
    always_comb begin
        in_ready = rst_n && ((r_state == StIdle) || (r_cnt == 4'd0));
        w_accept = in_valid && in_ready;
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_out_d   = r_out;
        if (w_accept) begin
            w_state_d = StHold;
            w_cnt_d   = CntLoad;
            w_out_d   = 8'b1 << input_data;
        end else if (r_state == StHold) begin
            if (r_cnt != 4'd0) begin
                w_cnt_d = r_cnt - 4'd1;
            end else begin
                w_state_d = StIdle;
                w_out_d   = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_out   <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_out   <= w_out_d;
        end
    end

    always_comb begin
        out       = r_out;
        out_valid = (r_state == StHold);
    end

`ifdef DEC_COUNT_EN
    logic [7:0] r_dec_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec_count <= 8'd0;
        end else if (w_accept && (r_dec_count != 8'hFF)) begin
            r_dec_count <= r_dec_count + 8'd1;
        end
    end

    always_comb dec_count = r_dec_count;
`endif

endmodule

// File: tb/tb_priority_decoder_3to8.sv
// Scoreboard bench for priority_decoder_3to8: two instances (HOLD_CYCLES 4 and 1) driven
// cycle by cycle; a hold-remaining model pushes expected outputs, popped after each edge.
module tb_priority_decoder_3to8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v4, v1;
    logic [2:0] d4, d1;
    logic       rdy4, rdy1, ov4, ov1;
    logic [7:0] o4, o1;
`ifdef DEC_COUNT_EN
    logic [7:0] cnt4, cnt1;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q4[$];
    logic [7:0] q1[$];
    int         rem4 = 0, rem1 = 0;
    logic [7:0] pat4 = 8'd0, pat1 = 8'd0;
    int         acc4 = 0, acc1 = 0;

    always #5 clk = ~clk;

    priority_decoder_3to8 #(.HOLD_CYCLES(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v4),
        .input_data (d4),
        .in_ready   (rdy4),
        .out        (o4),
        .out_valid  (ov4)
`ifdef DEC_COUNT_EN
        ,
        .dec_count  (cnt4)
`endif
    );

    priority_decoder_3to8 #(.HOLD_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v1),
        .input_data (d1),
        .in_ready   (rdy1),
        .out        (o1),
        .out_valid  (ov1)
`ifdef DEC_COUNT_EN
        ,
        .dec_count  (cnt1)
`endif
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // rem = cycles of the current pattern still to be shown, including this one.
    task automatic model(input int h, input logic rstn, input logic v, input logic [2:0] d,
                         inout int rem, inout logic [7:0] pat, output logic rdy,
                         output logic acc);
        rdy = rstn && (rem <= 1);
        acc = v && rdy;
        if (!rstn) begin
            rem = 0;
            pat = 8'd0;
        end else if (acc) begin
            pat = 8'b1 << d;
            rem = h;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) pat = 8'd0;
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cyc(input logic rstn, input logic iv4, input logic [2:0] id4,
                       input logic iv1, input logic [2:0] id1);
        logic       er4, er1, a4, a1;
        logic [7:0] e;
        rst_n = rstn;
        v4    = iv4;
        d4    = id4;
        v1    = iv1;
        d1    = id1;
        model(4, rstn, iv4, id4, rem4, pat4, er4, a4);
        model(1, rstn, iv1, id1, rem1, pat1, er1, a1);
        if (!rstn) acc4 = 0; else if (a4 && acc4 < 255) acc4++;
        if (!rstn) acc1 = 0; else if (a1 && acc1 < 255) acc1++;
        q4.push_back(pat4);
        q1.push_back(pat1);
        #1;
        chk8("ready4", {7'd0, rdy4}, {7'd0, er4});
        chk8("ready1", {7'd0, rdy1}, {7'd0, er1});
        @(posedge clk);
        #1;
        e = q4.pop_front();
        chk8("out4", o4, e);
        chk8("valid4", {7'd0, ov4}, {7'd0, (e != 8'd0)});
        e = q1.pop_front();
        chk8("out1", o1, e);
        chk8("valid1", {7'd0, ov1}, {7'd0, (e != 8'd0)});
`ifdef DEC_COUNT_EN
        chk8("count4", cnt4, 8'(acc4));
        chk8("count1", cnt1, 8'(acc1));
`endif
    endtask

    initial begin
        logic [7:0] walk;
        rst_n = 1'b0;
        v4    = 1'b1;
        d4    = 3'd5;
        v1    = 1'b1;
        d1    = 3'd5;
        @(posedge clk);
        #1;

        // Reset held for 2 cycles with a valid code pending
        cyc(1'b0, 1'b1, 3'd5, 1'b1, 3'd5);
        cyc(1'b0, 1'b1, 3'd5, 1'b1, 3'd5);
        chk8("rst_out", o4, 8'h00);
        chk8("rst_valid", {7'd0, ov4}, 8'h00);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);

        // Single accept of code 2, held 4 cycles then zero
        cyc(1'b1, 1'b1, 3'd2, 1'b0, 3'd0);
        chk8("hold2_c1", o4, 8'h04);
        for (int i = 2; i <= 4; i++) begin
            cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
            chk8("hold2", o4, 8'h04);
        end
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        chk8("hold2_end", o4, 8'h00);

        // Back-to-back: code 0 then 7 with valid held
        cyc(1'b1, 1'b1, 3'd0, 1'b0, 3'd0);
        chk8("b2b_c1", o4, 8'h01);
        for (int i = 0; i < 3; i++) begin
            chk8("b2b_busy", {7'd0, rdy4}, 8'h00);
            cyc(1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
            chk8("b2b_hold", o4, 8'h01);
        end
        cyc(1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
        chk8("b2b_next", o4, 8'h80);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);

        // HOLD_CYCLES=1 walk of codes 0..7
        walk = 8'h01;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b0, 3'd0, 1'b1, 3'(c));
            chk8("walk", o1, walk);
            walk = walk << 1;
        end
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        chk8("walk_end", o1, 8'h00);

        // Reset during second HOLD cycle abandons the pattern
        cyc(1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
        chk8("mid_c1", o4, 8'h08);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        chk8("mid_rst_out", o4, 8'h00);
        chk8("mid_rst_valid", {7'd0, ov4}, 8'h00);

        // Random traffic on both instances
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        // 300 accepts at HOLD_CYCLES=1 then reset
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 3'd0, 1'b1, 3'(i));
`ifdef DEC_COUNT_EN
        chk8("count_sat", cnt1, 8'hFF);
`endif
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
`ifdef DEC_COUNT_EN
        chk8("count_rst", cnt1, 8'h00);
`endif
        chk8("final_out1", o1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
